// File: rtl/multi_road_traffic_controller_pkg.sv
// Shared types and constants for the multi-road intersection controller.
// Holds the controller state encoding, lamp patterns and the counter sizing helper.
package traffic_pkg;

  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    AR1   = 3'd2,
    SG    = 3'd3,
    SY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [2:0] L_GREEN  = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b001;
  localparam logic [2:0] L_OFF    = 3'b000;

  // Width of a counter that can reach the longest phase duration.
  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    m = (e > m) ? e : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/multi_road_traffic_controller_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping.
module rr_arbiter
  import traffic_pkg::*;
#(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         valid
);

  // Scan from the pointer; the first hit locks the result.
  always_comb begin
    int   idx;
    logic hit;
    idx   = 0;
    hit   = 1'b0;
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx   = (int'(ptr) + k) % N;
      hit   = !valid && req[W'(idx)];
      grant = hit ? W'(idx) : grant;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/multi_road_traffic_controller.sv
// Intersection controller: one highway against NUM_SIDE local roads, round-robin
// service of waiting roads, and a night flashing mode entered only from highway green.
module multi_road_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_SIDE   = 2,
  parameter int HG_MIN     = 80,
  parameter int Y_CYC      = 20,
  parameter int AR_CYC     = 1,
  parameter int SG_CYC     = 80,
  parameter int FLASH_HALF = 8,
  localparam int SEL_W     = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SIDE-1:0]   lr_has_car,
  input  logic                  night,
  output logic [2:0]            hw_light,
  output logic [3*NUM_SIDE-1:0] lr_light,
  output logic [SEL_W-1:0]      side_sel
);

  localparam int CNT_W = cnt_width(HG_MIN, SG_CYC, Y_CYC, AR_CYC, FLASH_HALF);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    blink;
  logic                    blink_nxt;
  logic [SEL_W-1:0]        ptr;
  logic [SEL_W-1:0]        ptr_nxt;
  logic [SEL_W-1:0]        grant_nxt;
  logic [SEL_W-1:0]        arb_grant;
  logic                    arb_valid;
  logic [2:0]              hw_nxt;
  logic [3*NUM_SIDE-1:0]   lr_nxt;

  rr_arbiter #(.N(NUM_SIDE), .W(SEL_W)) u_arb (
    .req   (lr_has_car),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  function automatic logic at_end(input logic [CNT_W-1:0] c, input int dur);
    return c == CNT_W'(dur - 1);
  endfunction

  // Next-state, phase counter, blink and round-robin bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    blink_nxt = blink;
    ptr_nxt   = ptr;
    grant_nxt = side_sel;
    case (state)
      HG: begin
        if (night) begin
          state_nxt = FLASH;
          cnt_nxt   = '0;
        end else if ((cnt >= CNT_W'(HG_MIN - 1)) && arb_valid) begin
          state_nxt = HY;
          cnt_nxt   = '0;
          grant_nxt = arb_grant;
        end else begin
          state_nxt = HG;
        end
      end
      HY: begin
        if (at_end(cnt, Y_CYC)) begin
          state_nxt = AR1;
          cnt_nxt   = '0;
        end else begin
          state_nxt = HY;
        end
      end
      AR1: begin
        if (at_end(cnt, AR_CYC)) begin
          state_nxt = SG;
          cnt_nxt   = '0;
        end else begin
          state_nxt = AR1;
        end
      end
      SG: begin
        if (at_end(cnt, SG_CYC)) begin
          state_nxt = SY;
          cnt_nxt   = '0;
        end else begin
          state_nxt = SG;
        end
      end
      SY: begin
        if (at_end(cnt, Y_CYC)) begin
          state_nxt = AR2;
          cnt_nxt   = '0;
        end else begin
          state_nxt = SY;
        end
      end
      AR2: begin
        if (at_end(cnt, AR_CYC)) begin
          state_nxt = HG;
          cnt_nxt   = '0;
          ptr_nxt   = (side_sel == SEL_W'(NUM_SIDE - 1)) ? '0 : side_sel + SEL_W'(1);
        end else begin
          state_nxt = AR2;
        end
      end
      FLASH: begin
        // Blink restarts dark on every entry so the flash pattern is deterministic.
        if (!night) begin
          state_nxt = AR2;
          cnt_nxt   = '0;
          blink_nxt = 1'b0;
        end else if (at_end(cnt, FLASH_HALF)) begin
          blink_nxt = ~blink;
          cnt_nxt   = '0;
        end else begin
          state_nxt = FLASH;
        end
      end
      default: begin
        state_nxt = HG;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Lamp decode of the upcoming state so the registered lamps track the state register.
  always_comb begin
    case (state_nxt)
      HG:      hw_nxt = L_GREEN;
      HY:      hw_nxt = L_YELLOW;
      FLASH:   hw_nxt = blink_nxt ? L_YELLOW : L_OFF;
      default: hw_nxt = L_RED;
    endcase
    lr_nxt = '0;
    for (int i = 0; i < NUM_SIDE; i++) begin
      if (state_nxt == FLASH) begin
        lr_nxt[3*i +: 3] = blink_nxt ? L_RED : L_OFF;
      end else if ((state_nxt == SG) && (grant_nxt == SEL_W'(i))) begin
        lr_nxt[3*i +: 3] = L_GREEN;
      end else if ((state_nxt == SY) && (grant_nxt == SEL_W'(i))) begin
        lr_nxt[3*i +: 3] = L_YELLOW;
      end else begin
        lr_nxt[3*i +: 3] = L_RED;
      end
    end
  end

  // State, counters and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HG;
      cnt      <= '0;
      blink    <= 1'b0;
      ptr      <= '0;
      side_sel <= '0;
      hw_light <= L_GREEN;
      lr_light <= {NUM_SIDE{L_RED}};
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      blink    <= blink_nxt;
      ptr      <= ptr_nxt;
      side_sel <= grant_nxt;
      hw_light <= hw_nxt;
      lr_light <= lr_nxt;
    end
  end

endmodule

// File: tb/tb_multi_road_traffic_controller.sv
// Self-checking bench: directed scenarios plus randomised traffic, all compared
// every cycle against a frame-schedule reference model of the intersection.
module tb_multi_road_traffic_controller;

  localparam int N      = 3;
  localparam int HG_MIN = 8;
  localparam int Y_CYC  = 3;
  localparam int AR_CYC = 1;
  localparam int SG_CYC = 5;
  localparam int FH     = 2;

  localparam logic [2:0] G   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] R   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef struct packed {
    logic [2:0]   hw;
    logic [3*N-1:0] lr;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           night;
  logic [N-1:0]   cars;
  logic [2:0]     hw;
  logic [3*N-1:0] lr;
  logic [1:0]     sel;

  int checks   = 0;
  int failures = 0;

  multi_road_traffic_controller #(
    .NUM_SIDE(N), .HG_MIN(HG_MIN), .Y_CYC(Y_CYC), .AR_CYC(AR_CYC),
    .SG_CYC(SG_CYC), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .rst(rst), .lr_has_car(cars), .night(night),
    .hw_light(hw), .lr_light(lr), .side_sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: highway idle, a queue of scheduled frames, or flashing.
  int     m_mode;
  int     m_hg_age;
  int     m_f_age;
  int     m_ptr;
  int     m_grant;
  int     skip [N];
  frame_t sched [$];

  function automatic logic [3*N-1:0] all_red();
    logic [3*N-1:0] v;
    for (int i = 0; i < N; i++) v[3*i +: 3] = R;
    return v;
  endfunction

  function automatic logic [3*N-1:0] one_lit(input int g, input logic [2:0] lamp);
    logic [3*N-1:0] v;
    v = all_red();
    v[3*g +: 3] = lamp;
    return v;
  endfunction

  task automatic push_side(input int g);
    for (int k = 0; k < Y_CYC; k++)  sched.push_back('{hw: Y, lr: all_red()});
    for (int k = 0; k < AR_CYC; k++) sched.push_back('{hw: R, lr: all_red()});
    for (int k = 0; k < SG_CYC; k++) sched.push_back('{hw: R, lr: one_lit(g, G)});
    for (int k = 0; k < Y_CYC; k++)  sched.push_back('{hw: R, lr: one_lit(g, Y)});
    for (int k = 0; k < AR_CYC; k++) sched.push_back('{hw: R, lr: all_red()});
  endtask

  task automatic model_step();
    int pick;
    if (rst) begin
      m_mode = 0; m_hg_age = 0; m_f_age = 0; m_ptr = 0; m_grant = 0;
      sched.delete();
      for (int i = 0; i < N; i++) skip[i] = 0;
    end else begin
      case (m_mode)
        0: begin
          if (night) begin
            m_mode = 2; m_f_age = 0;
          end else if (m_hg_age >= HG_MIN - 1 && cars != '0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
              if (pick < 0 && cars[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            for (int i = 0; i < N; i++) begin
              if (i == pick) skip[i] = 0;
              else if (cars[i]) skip[i]++;
              else skip[i] = 0;
              check_eq("fairness", skip[i] < N, 1);
            end
            m_grant = pick;
            push_side(pick);
            m_mode = 1;
          end else begin
            m_hg_age++;
          end
        end
        1: begin
          void'(sched.pop_front());
          if (sched.size() == 0) begin
            m_mode = 0; m_hg_age = 0; m_ptr = (m_grant + 1) % N;
          end
        end
        default: begin
          if (!night) begin
            for (int k = 0; k < AR_CYC; k++) sched.push_back('{hw: R, lr: all_red()});
            m_mode = 1;
          end else begin
            m_f_age++;
          end
        end
      endcase
    end
  endtask

  task automatic compare();
    frame_t e;
    int lit;
    if (m_mode == 0) e = '{hw: G, lr: all_red()};
    else if (m_mode == 1) e = sched[0];
    else if (((m_f_age / FH) % 2) == 1) e = '{hw: Y, lr: all_red()};
    else e = '{hw: OFF, lr: '0};
    check_eq("hw_light", hw, e.hw);
    check_eq("lr_light", lr, e.lr);
    check_eq("side_sel", sel, m_grant);
    lit = (hw == G || hw == Y) ? 1 : 0;
    for (int i = 0; i < N; i++)
      if (lr[3*i +: 3] == G || lr[3*i +: 3] == Y) lit++;
    check_eq("safety", lit <= 1, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int got [$];
    logic [2:0] prev_hw;
    rst = 1'b1; night = 1'b0; cars = '0;

    // 1: idle highway, no requests
    do_reset(3);
    repeat (50) tick();
    check_eq("idle_hw", hw, G);
    check_eq("idle_lr", lr, {R, R, R});

    // 2: single request on road 1, timing of the first side cycle
    do_reset(3);
    n = 0;
    while (hw !== Y && n < 50) begin
      if (n == 2) cars = 3'b010;
      tick();
      n++;
    end
    check_eq("hy_entry_cycles", n, 8);
    cars = '0;
    repeat (13) tick();
    check_eq("back_to_hg", hw, G);
    check_eq("grant_road1", sel, 1);

    // 3: all roads request, grants rotate 0,1,2 then wrap to 0
    cars = 3'b111;
    do_reset(3);
    prev_hw = G;
    n = 0;
    while (got.size() < 4 && n < 200) begin
      tick();
      n++;
      if (prev_hw == G && hw == Y) got.push_back(int'(sel));
      prev_hw = hw;
    end
    check_eq("rr_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) check_eq("rr_order", got[i], i % N);

    // 4: night during SG completes the side cycle, flashes, then re-arms HG_MIN
    cars = 3'b001;
    do_reset(2);
    n = 0;
    while (lr[2:0] !== G && n < 60) begin tick(); n++; end
    check_eq("reach_sg", lr[2:0], G);
    night = 1'b1; cars = '0;
    n = 0;
    while (hw !== Y && n < 40) begin tick(); n++; end
    check_eq("flash_on", hw, Y);
    repeat (7) tick();
    night = 1'b0; cars = 3'b010;
    n = 0;
    while (hw !== Y && n < 40) begin tick(); n++; end
    check_eq("post_flash_hy", n, 10);
    repeat (15) tick();

    // 5: reset mid-SG
    cars = 3'b100;
    do_reset(2);
    n = 0;
    while (lr[8:6] !== G && n < 60) begin tick(); n++; end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_hw", hw, G);
    check_eq("rst_lr", lr, {R, R, R});
    check_eq("rst_sel", sel, 0);

    // 6: randomised traffic and night requests
    cars = '0; night = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if ($urandom_range(0, 7) == 0) cars = N'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) night = ~night;
      rst = ($urandom_range(0, 2999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
